// File: rtl/mic1_io_bridge.sv
// Memory-mapped byte I/O bridge between the mic1 data port and main_memory: RX/TX FIFOs,
// status register and sticky flags. Define MIC1_IO_LOOPBACK_EN to build the TX->RX loopback bit.
module mic1_io_bridge #(
  parameter logic [31:0] DATA_ADDR = 32'hFFFF_FFFD,
  parameter logic [31:0] STAT_ADDR = 32'hFFFF_FFFC,
  parameter int          DATA_W    = 8,
  parameter int          RX_DEPTH  = 16,
  parameter int          TX_DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);

  logic              hit_d, hit_s, hit;
  logic              data_rd, data_wr, stat_rd, stat_wr;
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [RX_AW-1:0]  rx_wptr, rx_rptr;
  logic [TX_AW-1:0]  tx_wptr, tx_rptr;
  logic [RX_AW:0]    rx_count;
  logic [TX_AW:0]    tx_count;
  logic              rx_empty, rx_full, tx_empty, tx_full;
  logic              rx_push, rx_pop, tx_push, tx_pop;
  logic [DATA_W-1:0] rx_push_data;
  logic              tx_ovf, rd_underflow, loopback, lb_move;
  logic              sel_io;
  logic [31:0]       io_q, io_d, status;
  logic              unused_wdata;

  function automatic logic [7:0] sat8(input logic [31:0] v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction

  assign hit_d     = (cpu_addr == DATA_ADDR);
  assign hit_s     = (cpu_addr == STAT_ADDR);
  assign hit       = hit_d | hit_s;
  assign mem_read  = cpu_read & ~hit;
  assign mem_write = cpu_write & ~hit;
  assign data_rd   = cpu_read & hit_d;
  assign data_wr   = cpu_write & hit_d;
  assign stat_rd   = cpu_read & hit_s;
  assign stat_wr   = cpu_write & hit_s;
  assign unused_wdata = ^cpu_wdata;

  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == (RX_AW+1)'(RX_DEPTH));
  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == (TX_AW+1)'(TX_DEPTH));

`ifdef MIC1_IO_LOOPBACK_EN
  always_ff @(posedge clk) begin
    if (reset)
      loopback <= 1'b0;
    else if (stat_wr)
      loopback <= cpu_wdata[7];
  end
  assign lb_move = loopback & ~tx_empty & ~rx_full;
`else
  assign loopback = 1'b0;
  assign lb_move  = 1'b0;
`endif

  // While looping back, the external streams are fenced off entirely
  assign rx_ready     = ~reset & ~rx_full & ~loopback;
  assign tx_valid     = ~tx_empty & ~loopback;
  assign tx_data      = tx_mem[tx_rptr];
  assign rx_push      = (rx_valid & rx_ready) | lb_move;
  assign rx_push_data = loopback ? tx_mem[tx_rptr] : rx_data;
  assign rx_pop       = data_rd & ~rx_empty;
  assign tx_push      = data_wr & ~tx_full;
  assign tx_pop       = (tx_valid & tx_ready) | lb_move;

  always_comb begin
    status        = '0;
    status[0]     = ~rx_empty;
    status[1]     = tx_full;
    status[2]     = tx_ovf;
    status[3]     = rd_underflow;
    status[7]     = loopback;
    status[15:8]  = sat8(32'(rx_count));
    status[23:16] = sat8(32'(tx_count));
  end

  always_comb begin
    io_d = '0;
    if (stat_rd)
      io_d = status;
    else if (rx_pop)
      io_d = 32'(rx_mem[rx_rptr]);
  end

  always_ff @(posedge clk) begin
    if (!reset && rx_push)
      rx_mem[rx_wptr] <= rx_push_data;
    if (!reset && tx_push)
      tx_mem[tx_wptr] <= cpu_wdata[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push)
        rx_wptr <= rx_wptr + RX_AW'(1);
      if (rx_pop)
        rx_rptr <= rx_rptr + RX_AW'(1);
      if (rx_push && !rx_pop)
        rx_count <= rx_count + (RX_AW+1)'(1);
      else if (rx_pop && !rx_push)
        rx_count <= rx_count - (RX_AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push)
        tx_wptr <= tx_wptr + TX_AW'(1);
      if (tx_pop)
        tx_rptr <= tx_rptr + TX_AW'(1);
      if (tx_push && !tx_pop)
        tx_count <= tx_count + (TX_AW+1)'(1);
      else if (tx_pop && !tx_push)
        tx_count <= tx_count - (TX_AW+1)'(1);
    end
  end

  // Sticky flags: a set in the same cycle as a write-1-to-clear wins
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ovf       <= 1'b0;
      rd_underflow <= 1'b0;
      sel_io       <= 1'b0;
      io_q         <= '0;
    end else begin
      if (data_wr && tx_full)
        tx_ovf <= 1'b1;
      else if (stat_wr && cpu_wdata[2])
        tx_ovf <= 1'b0;
      if (data_rd && rx_empty)
        rd_underflow <= 1'b1;
      else if (stat_wr && cpu_wdata[3])
        rd_underflow <= 1'b0;
      sel_io <= cpu_read & hit;
      if (cpu_read && hit)
        io_q <= io_d;
    end
  end

  assign cpu_rdata = sel_io ? io_q : mem_rdata;

endmodule

// File: tb/tb_mic1_io_bridge.sv
// Self-checking bench for mic1_io_bridge: directed vector table, hand-written corner sequences
// and randomized traffic compared against a queue-based reference model.
module tb_mic1_io_bridge;

  localparam logic [31:0] DATA_ADDR = 32'hFFFF_FFFD;
  localparam logic [31:0] STAT_ADDR = 32'hFFFF_FFFC;
  localparam int          RX_DEPTH  = 4;
  localparam int          TX_DEPTH  = 16;

  typedef struct packed {
    logic        rst;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rxv;
    logic [7:0]  rxd;
    logic        txr;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, cpu_read, cpu_write;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_rdata = '0;
  logic [7:0]  rx_data, tx_data;
  logic        rx_valid, rx_ready, tx_valid, tx_ready;

  int passed = 0;
  int total  = 0;

  // Reference model state
  bit [7:0]  rx_q[$];
  bit [7:0]  tx_q[$];
  bit        m_ovf, m_und, m_lb, m_sel;
  bit [31:0] m_ioq, m_memq;
  bit [31:0] m_mem [256];
  bit [31:0] bench_mem [256];

  mic1_io_bridge #(
    .DATA_ADDR(DATA_ADDR), .STAT_ADDR(STAT_ADDR), .DATA_W(8),
    .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  // main_memory stand-in with one cycle read latency
  always @(posedge clk) begin
    if (mem_read)
      mem_rdata <= bench_mem[cpu_addr[7:0]];
    if (mem_write)
      bench_mem[cpu_addr[7:0]] <= cpu_wdata;
  end

  function automatic stim_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic rxv, input logic [7:0] rxd,
                               input logic txr);
    stim_t s;
    s.rst = 1'b0; s.rd = rd; s.wr = wr; s.addr = addr; s.wdata = wdata;
    s.rxv = rxv; s.rxd = rxd; s.txr = txr;
    return s;
  endfunction

  function automatic bit [7:0] sat(input int n);
    return (n > 255) ? 8'hFF : n[7:0];
  endfunction

  function automatic bit [31:0] model_status();
    bit [31:0] v = '0;
    v[0]     = (rx_q.size() != 0);
    v[1]     = (tx_q.size() == TX_DEPTH);
    v[2]     = m_ovf;
    v[3]     = m_und;
    v[7]     = m_lb;
    v[15:8]  = sat(rx_q.size());
    v[23:16] = sat(tx_q.size());
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp)
      passed++;
    else
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic modelEdge(input stim_t s, input bit e_rxr, input bit e_txv);
    bit hd, hs, lbm, rx_pop, tx_pop, tx_wr, tx_was_full, sel;
    bit [7:0]  head;
    bit [31:0] ioval;
    hd = (s.addr == DATA_ADDR);
    hs = (s.addr == STAT_ADDR);
    if (s.rd && !(hd || hs)) m_memq = m_mem[s.addr[7:0]];
    if (s.wr && !(hd || hs)) m_mem[s.addr[7:0]] = s.wdata;
    if (s.rst) begin
      rx_q.delete(); tx_q.delete();
      m_ovf = 0; m_und = 0; m_lb = 0; m_sel = 0;
      return;
    end
    lbm         = m_lb && tx_q.size() != 0 && rx_q.size() < RX_DEPTH;
    rx_pop      = s.rd && hd && rx_q.size() != 0;
    tx_pop      = (e_txv && s.txr) || lbm;
    tx_wr       = s.wr && hd;
    tx_was_full = (tx_q.size() == TX_DEPTH);
    sel         = s.rd && (hd || hs);
    ioval       = hs ? model_status() : (rx_pop ? 32'(rx_q[0]) : 32'h0);
    head        = '0;
    if (rx_pop) void'(rx_q.pop_front());
    if (tx_pop) head = tx_q.pop_front();
    if (lbm) rx_q.push_back(head);
    else if (s.rxv && e_rxr) rx_q.push_back(s.rxd);
    if (tx_wr && !tx_was_full) tx_q.push_back(s.wdata[7:0]);
    if (tx_wr && tx_was_full) m_ovf = 1;
    else if (s.wr && hs && s.wdata[2]) m_ovf = 0;
    if (s.rd && hd && !rx_pop) m_und = 1;
    else if (s.wr && hs && s.wdata[3]) m_und = 0;
`ifdef MIC1_IO_LOOPBACK_EN
    if (s.wr && hs) m_lb = s.wdata[7];
`endif
    m_sel = sel;
    if (sel) m_ioq = ioval;
  endtask

  // One clock: drive at negedge, check decode/stream outputs, then check read data after the edge
  task automatic applyStimulus(input stim_t s);
    bit hit, e_rxr, e_txv;
    @(negedge clk);
    reset = s.rst; cpu_read = s.rd; cpu_write = s.wr; cpu_addr = s.addr;
    cpu_wdata = s.wdata; rx_valid = s.rxv; rx_data = s.rxd; tx_ready = s.txr;
    #1;
    hit   = (s.addr == DATA_ADDR) || (s.addr == STAT_ADDR);
    e_rxr = !s.rst && rx_q.size() < RX_DEPTH && !m_lb;
    e_txv = tx_q.size() != 0 && !m_lb;
    checkOutput("mem_read", mem_read, s.rd && !hit);
    checkOutput("mem_write", mem_write, s.wr && !hit);
    checkOutput("rx_ready", rx_ready, e_rxr);
    checkOutput("tx_valid", tx_valid, e_txv);
    if (e_txv) checkOutput("tx_data", tx_data, tx_q[0]);
    @(posedge clk);
    modelEdge(s, e_rxr, e_txv);
    #1;
    checkOutput("cpu_rdata", cpu_rdata, m_sel ? m_ioq : m_memq);
  endtask

  task automatic idle(input logic txr);
    applyStimulus(mk(0, 0, 32'h0, 32'h0, 0, 8'h0, txr));
  endtask

  vec_t tbl[16];

  initial begin
    stim_t s;
    reset = 1; cpu_read = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
    rx_valid = 0; rx_data = 0; tx_ready = 0;
    repeat (2) @(posedge clk);

    s = mk(0, 0, 32'h0, 32'h0, 0, 8'h0, 0);
    s.rst = 1;
    applyStimulus(s);
    checkOutput("reset_rdata", cpu_rdata, 32'h0);
    checkOutput("reset_rx_ready", rx_ready, 1'b0);
    idle(0);
    checkOutput("post_reset_rx_ready", rx_ready, 1'b1);

    tbl[0]  = '{mk(0, 1, 32'h10, 32'h1234_5678, 0, 8'h00, 0), 1'b0, 32'h0};
    tbl[1]  = '{mk(1, 0, 32'h10, 32'h0, 0, 8'h00, 0), 1'b1, 32'h1234_5678};
    tbl[2]  = '{mk(0, 0, 32'h0, 32'h0, 1, 8'h33, 0), 1'b0, 32'h0};
    tbl[3]  = '{mk(0, 0, 32'h0, 32'h0, 1, 8'h34, 0), 1'b0, 32'h0};
    tbl[4]  = '{mk(0, 0, 32'h0, 32'h0, 1, 8'h0A, 0), 1'b0, 32'h0};
    tbl[5]  = '{mk(1, 0, DATA_ADDR, 32'h0, 0, 8'h00, 0), 1'b1, 32'h33};
    tbl[6]  = '{mk(1, 0, DATA_ADDR, 32'h0, 0, 8'h00, 0), 1'b1, 32'h34};
    tbl[7]  = '{mk(1, 0, DATA_ADDR, 32'h0, 0, 8'h00, 0), 1'b1, 32'h0A};
    tbl[8]  = '{mk(1, 0, DATA_ADDR, 32'h0, 0, 8'h00, 0), 1'b1, 32'h00};
    tbl[9]  = '{mk(1, 0, STAT_ADDR, 32'h0, 0, 8'h00, 0), 1'b1, 32'h0000_0008};
    tbl[10] = '{mk(0, 1, STAT_ADDR, 32'h08, 0, 8'h00, 0), 1'b0, 32'h0};
    tbl[11] = '{mk(1, 0, STAT_ADDR, 32'h0, 0, 8'h00, 0), 1'b1, 32'h0};
    tbl[12] = '{mk(0, 1, DATA_ADDR, 32'h41, 0, 8'h00, 0), 1'b0, 32'h0};
    tbl[13] = '{mk(1, 0, STAT_ADDR, 32'h0, 0, 8'h00, 0), 1'b1, 32'h0001_0000};
    tbl[14] = '{mk(0, 0, 32'h0, 32'h0, 0, 8'h00, 1), 1'b0, 32'h0};
    tbl[15] = '{mk(1, 0, STAT_ADDR, 32'h0, 0, 8'h00, 0), 1'b1, 32'h0};
    for (int i = 0; i < 16; i++) begin
      applyStimulus(tbl[i].s);
      if (tbl[i].chk) checkOutput($sformatf("vec%0d_rdata", i), cpu_rdata, tbl[i].exp);
    end

    // RX full
    for (int i = 0; i < 6; i++)
      applyStimulus(mk(0, 0, 32'h0, 32'h0, 1, 8'(8'h60 + i), 0));
    checkOutput("rxfull_ready", rx_ready, 1'b0);
    applyStimulus(mk(1, 0, STAT_ADDR, 32'h0, 0, 8'h0, 0));
    checkOutput("rxfull_status", cpu_rdata, 32'h0000_0401);
    applyStimulus(mk(1, 0, DATA_ADDR, 32'h0, 0, 8'h0, 0));
    checkOutput("rxfull_first", cpu_rdata, 32'h60);
    checkOutput("rxfull_ready_back", rx_ready, 1'b1);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(mk(1, 0, DATA_ADDR, 32'h0, 0, 8'h0, 0));
      checkOutput("rxfull_drain", cpu_rdata, 32'(8'h60 + i));
    end

    // TX overflow
    for (int i = 0; i < 17; i++)
      applyStimulus(mk(0, 1, DATA_ADDR, 32'(8'h41 + i), 0, 8'h0, 0));
    applyStimulus(mk(1, 0, STAT_ADDR, 32'h0, 0, 8'h0, 0));
    checkOutput("txovf_status", cpu_rdata, 32'h0010_0006);
    for (int i = 0; i < 16; i++) begin
      checkOutput("txovf_valid", tx_valid, 1'b1);
      checkOutput("txovf_data", tx_data, 32'(8'h41 + i));
      idle(1);
    end
    checkOutput("txovf_empty", tx_valid, 1'b0);
    applyStimulus(mk(1, 0, STAT_ADDR, 32'h0, 0, 8'h0, 0));
    checkOutput("txovf_sticky", cpu_rdata, 32'h0000_0004);
    applyStimulus(mk(0, 1, STAT_ADDR, 32'h04, 0, 8'h0, 0));
    applyStimulus(mk(1, 0, STAT_ADDR, 32'h0, 0, 8'h0, 0));
    checkOutput("txovf_cleared", cpu_rdata, 32'h0);

    // Simultaneous TX push and pop
    for (int i = 0; i < 8; i++)
      applyStimulus(mk(0, 1, DATA_ADDR, 32'(8'h70 + i), 0, 8'h0, 0));
    applyStimulus(mk(0, 1, DATA_ADDR, 32'h78, 0, 8'h0, 1));
    applyStimulus(mk(1, 0, STAT_ADDR, 32'h0, 0, 8'h0, 0));
    checkOutput("simul_status", cpu_rdata, 32'h0008_0000);
    for (int i = 0; i < 8; i++) begin
      checkOutput("simul_order", tx_data, 32'(8'h71 + i));
      idle(1);
    end

    // Reset with traffic in both FIFOs and a pending status read
    for (int i = 0; i < 3; i++)
      applyStimulus(mk(0, 1, DATA_ADDR, 32'(8'h31 + i), 1, 8'(8'h21 + i), 0));
    s = mk(1, 0, STAT_ADDR, 32'h0, 0, 8'h0, 0);
    s.rst = 1;
    applyStimulus(s);
    checkOutput("rst_tx_valid", tx_valid, 1'b0);
    applyStimulus(mk(1, 0, STAT_ADDR, 32'h0, 0, 8'h0, 0));
    checkOutput("rst_status", cpu_rdata, 32'h0);

`ifdef MIC1_IO_LOOPBACK_EN
    applyStimulus(mk(0, 1, STAT_ADDR, 32'h80, 0, 8'h0, 1));
    applyStimulus(mk(0, 1, DATA_ADDR, 32'h55, 0, 8'h0, 1));
    checkOutput("lb_tx_valid", tx_valid, 1'b0);
    idle(1);
    applyStimulus(mk(1, 0, DATA_ADDR, 32'h0, 0, 8'h0, 1));
    checkOutput("lb_data", cpu_rdata, 32'h55);
    applyStimulus(mk(0, 1, STAT_ADDR, 32'h00, 0, 8'h0, 0));
`else
    applyStimulus(mk(0, 1, STAT_ADDR, 32'h80, 0, 8'h0, 0));
    applyStimulus(mk(1, 0, STAT_ADDR, 32'h0, 0, 8'h0, 0));
    checkOutput("lb_absent", cpu_rdata, 32'h0);
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      int op, asel;
      logic [31:0] addr;
      asel = $urandom_range(0, 3);
      addr = (asel == 0) ? DATA_ADDR : (asel == 1) ? STAT_ADDR : 32'($urandom_range(0, 31));
      op = $urandom_range(0, 9);
      s = mk(op >= 4 && op <= 6, op >= 7, addr, $urandom, 1'($urandom_range(0, 1)),
             8'($urandom), $urandom_range(0, 2) != 0);
      s.rst = ($urandom_range(0, 199) == 0);
      applyStimulus(s);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
